strela_csr_gen: RTL

Parametrised control/status register block for the STRELA CGRA that replaces the fixed 4-in/4-out register file. It sits between the host MMIO register interface and the CGRA core. It generates per-channel memory-node parameters for any number of input and output nodes. Compared to the fixed block, it adds saturating per-master stall counters, a maskable done interrupt with a W1C pending bit, and error responses for unmapped addresses.

---
 rtl/strela_csr_gen.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/strela_csr_gen.sv
// Host-visible CSR block for the STRELA CGRA: control pulses, status/irq, per-node memory parameters, perf counters.
// Reads are combinational (zero wait states); writes, pulses and counter updates land on the next clk_i edge.
// Never backpressures: reg_ready_o is constant 1; unmapped or read-only writes return reg_error_o with no state change.
module strela_csr_gen #(
  parameter int IN_NODES  = 4,
  parameter int OUT_NODES = 4,
  parameter int NODES     = 8,
  parameter int CTR_W     = 32,
  parameter int AW        = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      reg_valid_i,
  input  logic                      reg_write_i,
  input  logic [AW-1:0]             reg_addr_i,
  input  logic [31:0]               reg_wdata_i,
  input  logic [3:0]                reg_wstrb_i,
  output logic [31:0]               reg_rdata_o,
  output logic                      reg_error_o,
  output logic                      reg_ready_o,
  output logic                      start_o,
  output logic                      clr_conf_o,
  output logic                      irq_o,
  input  logic                      exec_done_i,
  input  logic                      conf_done_i,
  input  logic                      state_conf_i,
  input  logic                      state_exec_i,
  input  logic [NODES-1:0]          mst_req_i,
  input  logic [NODES-1:0]          mst_gnt_i,
  output logic [31:0]               conf_addr_o,
  output logic [15:0]               conf_size_o,
  output logic [IN_NODES*32-1:0]    imn_addr_o,
  output logic [IN_NODES*16-1:0]    imn_size_o,
  output logic [IN_NODES*16-1:0]    imn_stride_o,
  output logic [OUT_NODES*32-1:0]   omn_addr_o,
  output logic [OUT_NODES*16-1:0]   omn_size_o
);

  // Word indices of the fixed registers and bases of the parametrised regions.
  localparam logic [31:0] W_CTRL   = 32'd0;
  localparam logic [31:0] W_STATUS = 32'd1;
  localparam logic [31:0] W_CADDR  = 32'd2;
  localparam logic [31:0] W_CSIZE  = 32'd3;
  localparam logic [31:0] W_TOTAL  = 32'd4;
  localparam logic [31:0] W_CONF   = 32'd5;
  localparam logic [31:0] W_EXEC   = 32'd6;
  localparam logic [31:0] W_STALL  = 32'd7;
  localparam logic [31:0] IMN_BASE = 32'd8;
  localparam logic [31:0] OMN_BASE = 32'(8 + 2*IN_NODES);
  localparam logic [31:0] STL_BASE = 32'(8 + 2*IN_NODES + 2*OUT_NODES);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

  // Byte-lane merge for 32-bit registers.
  function automatic logic [31:0] f_merge32(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Byte-lane merge for 16-bit fields.
  function automatic logic [15:0] f_merge16(input logic [15:0] old_v,
                                            input logic [15:0] new_v,
                                            input logic [1:0]  strb);
    logic [15:0] res;
    res[7:0]  = strb[0] ? new_v[7:0]  : old_v[7:0];
    res[15:8] = strb[1] ? new_v[15:8] : old_v[15:8];
    return res;
  endfunction

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CTR_W-1:0] f_sat(input logic [CTR_W-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_ONE;
  endfunction

  // Control / status state
  logic r_start, r_clr_param, r_clr_conf, r_ctr_rst;
  logic r_ctr_en, r_irq_en;
  logic r_exec_done, r_conf_done, r_irq_pend;

  // Parameter registers
  logic [31:0] r_conf_addr;
  logic [15:0] r_conf_size;
  logic [31:0] r_imn_addr   [IN_NODES];
  logic [15:0] r_imn_size   [IN_NODES];
  logic [15:0] r_imn_stride [IN_NODES];
  logic [31:0] r_omn_addr   [OUT_NODES];
  logic [15:0] r_omn_size   [OUT_NODES];

  // Performance counters
  logic [CTR_W-1:0] r_ctr_total, r_ctr_conf, r_ctr_exec, r_ctr_stall;
  logic [CTR_W-1:0] r_mst_ctr [NODES];

  // Decode results
  logic [31:0] w_idx;
  logic        w_hit;
  logic        w_ro;
  logic [31:0] w_rd;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_status;
  logic [NODES-1:0] w_mst_stall;
  logic        w_unused;

  assign w_idx       = 32'(reg_addr_i[AW-1:2]);
  assign w_unused    = ^reg_addr_i[1:0];
  assign w_mst_stall = mst_req_i & ~mst_gnt_i;

  // Address decode and read-data mux over the whole word map.
  always_comb begin
    w_hit = 1'b0;
    w_ro  = 1'b0;
    w_rd  = '0;
    if (w_idx < IMN_BASE) begin
      w_hit = 1'b1;
      case (w_idx[2:0])
        3'd0: w_rd = {26'd0, r_irq_en, r_ctr_rst, r_ctr_en, r_clr_conf, r_clr_param, r_start};
        3'd1: w_rd = {29'd0, r_irq_pend, r_conf_done, r_exec_done};
        3'd2: w_rd = r_conf_addr;
        3'd3: w_rd = {16'd0, r_conf_size};
        3'd4: begin w_ro = 1'b1; w_rd = 32'(r_ctr_total); end
        3'd5: begin w_ro = 1'b1; w_rd = 32'(r_ctr_conf);  end
        3'd6: begin w_ro = 1'b1; w_rd = 32'(r_ctr_exec);  end
        default: begin w_ro = 1'b1; w_rd = 32'(r_ctr_stall); end
      endcase
    end
    for (int i = 0; i < IN_NODES; i++) begin
      if (w_idx == IMN_BASE + 32'(2*i)) begin
        w_hit = 1'b1;
        w_rd  = r_imn_addr[i];
      end
      if (w_idx == IMN_BASE + 32'(2*i + 1)) begin
        w_hit = 1'b1;
        w_rd  = {r_imn_stride[i], r_imn_size[i]};
      end
    end
    for (int j = 0; j < OUT_NODES; j++) begin
      if (w_idx == OMN_BASE + 32'(2*j)) begin
        w_hit = 1'b1;
        w_rd  = r_omn_addr[j];
      end
      if (w_idx == OMN_BASE + 32'(2*j + 1)) begin
        w_hit = 1'b1;
        w_rd  = {16'd0, r_omn_size[j]};
      end
    end
    for (int k = 0; k < NODES; k++) begin
      if (w_idx == STL_BASE + 32'(k)) begin
        w_hit = 1'b1;
        w_ro  = 1'b1;
        w_rd  = 32'(r_mst_ctr[k]);
      end
    end
  end

  assign w_wr        = reg_valid_i & reg_write_i & w_hit & ~w_ro;
  assign w_wr_ctrl   = w_wr & (w_idx == W_CTRL);
  assign w_wr_status = w_wr & (w_idx == W_STATUS);

  assign reg_ready_o = 1'b1;
  assign reg_error_o = reg_valid_i & (~w_hit | (reg_write_i & w_ro));
  assign reg_rdata_o = (reg_valid_i & ~reg_write_i & w_hit) ? w_rd : 32'd0;

  // CTRL pulses, enables, done flags and the interrupt pending bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_start     <= 1'b0;
      r_clr_param <= 1'b0;
      r_clr_conf  <= 1'b0;
      r_ctr_rst   <= 1'b0;
      r_ctr_en    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_exec_done <= 1'b0;
      r_conf_done <= 1'b0;
      r_irq_pend  <= 1'b0;
    end else begin
      r_start     <= w_wr_ctrl & reg_wstrb_i[0] & reg_wdata_i[0];
      r_clr_param <= w_wr_ctrl & reg_wstrb_i[0] & reg_wdata_i[1];
      r_clr_conf  <= w_wr_ctrl & reg_wstrb_i[0] & reg_wdata_i[2];
      r_ctr_rst   <= w_wr_ctrl & reg_wstrb_i[0] & reg_wdata_i[4];
      if (w_wr_ctrl & reg_wstrb_i[0]) begin
        r_ctr_en <= reg_wdata_i[3];
        r_irq_en <= reg_wdata_i[5];
      end
      // Clearing sources take priority over a coincident done event.
      if (r_start | r_clr_param) r_exec_done <= 1'b0;
      else if (exec_done_i)      r_exec_done <= 1'b1;
      if (r_clr_conf)            r_conf_done <= 1'b0;
      else if (conf_done_i)      r_conf_done <= 1'b1;
      // A new done event beats a coincident software acknowledge.
      if (exec_done_i & r_irq_en) r_irq_pend <= 1'b1;
      else if (w_wr_status & reg_wstrb_i[0] & reg_wdata_i[2]) r_irq_pend <= 1'b0;
    end
  end

  // Parameter registers: software writes, with clr_param overriding any same-cycle write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_conf_addr <= '0;
      r_conf_size <= '0;
      for (int i = 0; i < IN_NODES; i++) begin
        r_imn_addr[i]   <= '0;
        r_imn_size[i]   <= '0;
        r_imn_stride[i] <= '0;
      end
      for (int j = 0; j < OUT_NODES; j++) begin
        r_omn_addr[j] <= '0;
        r_omn_size[j] <= '0;
      end
    end else if (r_clr_param) begin
      r_conf_addr <= '0;
      r_conf_size <= '0;
      for (int i = 0; i < IN_NODES; i++) begin
        r_imn_addr[i]   <= '0;
        r_imn_size[i]   <= '0;
        r_imn_stride[i] <= '0;
      end
      for (int j = 0; j < OUT_NODES; j++) begin
        r_omn_addr[j] <= '0;
        r_omn_size[j] <= '0;
      end
    end else if (w_wr) begin
      if (w_idx == W_CADDR) r_conf_addr <= f_merge32(r_conf_addr, reg_wdata_i, reg_wstrb_i);
      if (w_idx == W_CSIZE) r_conf_size <= f_merge16(r_conf_size, reg_wdata_i[15:0], reg_wstrb_i[1:0]);
      for (int i = 0; i < IN_NODES; i++) begin
        if (w_idx == IMN_BASE + 32'(2*i)) begin
          r_imn_addr[i] <= f_merge32(r_imn_addr[i], reg_wdata_i, reg_wstrb_i);
        end
        if (w_idx == IMN_BASE + 32'(2*i + 1)) begin
          r_imn_size[i]   <= f_merge16(r_imn_size[i], reg_wdata_i[15:0], reg_wstrb_i[1:0]);
          r_imn_stride[i] <= f_merge16(r_imn_stride[i], reg_wdata_i[31:16], reg_wstrb_i[3:2]);
        end
      end
      for (int j = 0; j < OUT_NODES; j++) begin
        if (w_idx == OMN_BASE + 32'(2*j)) begin
          r_omn_addr[j] <= f_merge32(r_omn_addr[j], reg_wdata_i, reg_wstrb_i);
        end
        if (w_idx == OMN_BASE + 32'(2*j + 1)) begin
          r_omn_size[j] <= f_merge16(r_omn_size[j], reg_wdata_i[15:0], reg_wstrb_i[1:0]);
        end
      end
    end
  end

  // Aggregate cycle counters; perf_ctr_rst beats increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ctr_total <= '0;
      r_ctr_conf  <= '0;
      r_ctr_exec  <= '0;
      r_ctr_stall <= '0;
    end else if (r_ctr_rst) begin
      r_ctr_total <= '0;
      r_ctr_conf  <= '0;
      r_ctr_exec  <= '0;
      r_ctr_stall <= '0;
    end else if (r_ctr_en) begin
      r_ctr_total <= f_sat(r_ctr_total);
      if (state_conf_i) r_ctr_conf  <= f_sat(r_ctr_conf);
      if (state_exec_i) r_ctr_exec  <= f_sat(r_ctr_exec);
      if (|w_mst_stall) r_ctr_stall <= f_sat(r_ctr_stall);
    end
  end

  // Per-master stall counters: request outstanding without grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NODES; k++) r_mst_ctr[k] <= '0;
    end else if (r_ctr_rst) begin
      for (int k = 0; k < NODES; k++) r_mst_ctr[k] <= '0;
    end else if (r_ctr_en) begin
      for (int k = 0; k < NODES; k++) begin
        if (w_mst_stall[k]) r_mst_ctr[k] <= f_sat(r_mst_ctr[k]);
      end
    end
  end

  assign start_o     = r_start;
  assign clr_conf_o  = r_clr_conf;
  assign irq_o       = r_irq_pend & r_irq_en;
  assign conf_addr_o = r_conf_addr;
  assign conf_size_o = r_conf_size;

  for (genvar gi = 0; gi < IN_NODES; gi++) begin : g_imn
    assign imn_addr_o[gi*32 +: 32]   = r_imn_addr[gi];
    assign imn_size_o[gi*16 +: 16]   = r_imn_size[gi];
    assign imn_stride_o[gi*16 +: 16] = r_imn_stride[gi];
  end

  for (genvar gj = 0; gj < OUT_NODES; gj++) begin : g_omn
    assign omn_addr_o[gj*32 +: 32] = r_omn_addr[gj];
    assign omn_size_o[gj*16 +: 16] = r_omn_size[gj];
  end

endmodule
